// File: rtl/gate_sequencer_if.sv
// gate_sequencer_if: control and result signals between the measurement
// sequencer and the rest of the frequency-counter datapath.
//   master: the controller/datapath side that drives start, continuous and count.
//   slave : the gate sequencer itself.
interface gate_sequencer_if #(
  parameter int unsigned COUNT_W = 32
);
  logic               start;
  logic               continuous;
  logic [COUNT_W-1:0] count;
  logic               count_clear;
  logic               gate;
  logic [COUNT_W-1:0] freq;
  logic               freq_valid;
  logic               overflow;
  logic               busy;
  logic [1:0]         range;

  modport master (
    output start, continuous, count,
    input  count_clear, gate, freq, freq_valid, overflow, busy, range
  );

  modport slave (
    input  start, continuous, count,
    output count_clear, gate, freq, freq_valid, overflow, busy, range
  );
endinterface

// File: rtl/gate_sequencer.sv
// gate_sequencer: measurement controller for the frequency counter.
// Sequence: CLEAR (1 cycle) -> GATE (GATE_CYCLES * 10^range cycles) ->
// SETTLE (HOLD_CYCLES cycles) -> LATCH (1 cycle), then IDLE or, in
// continuous mode, straight back to CLEAR.
// Optional macro GATE_AUTORANGE_EN: adds the range register and the decade
// counter that stretches the gate x10 per range step. Without it range is
// tied to 0 and the gate is always GATE_CYCLES long.
module gate_sequencer #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned COUNT_W     = 32,
  parameter int unsigned MAX_COUNT   = 99999999,
  parameter int unsigned LOW_THRESH  = 1000
) (
  input  logic             clock,
  input  logic             reset,
  gate_sequencer_if.slave  bus
);

  // One timer serves both the gate window and the settle wait, so it must
  // hold the larger of the two terminal values.
  localparam int unsigned TIMER_MAX = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
  localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TIMER_W-1:0] GATE_LAST = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [COUNT_W-1:0] MAX_VAL   = COUNT_W'(MAX_COUNT);

  // Reject configurations the timing cannot honour.
  if (GATE_CYCLES < 1 || HOLD_CYCLES < 1 || LOW_THRESH > MAX_COUNT) begin : g_param_check
    $error("gate_sequencer: invalid parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    LATCH
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [TIMER_W-1:0] timer_reg;
  logic               gate_done;
  logic               settle_done;
  logic               count_clear_next;
  logic               gate_next;
  logic               busy_next;
  logic               over_max;
  logic [COUNT_W-1:0] freq_reg;
  logic               freq_valid_reg;
  logic               overflow_reg;

  assign over_max    = (bus.count > MAX_VAL);
  assign settle_done = (timer_reg == HOLD_LAST);

`ifdef GATE_AUTORANGE_EN
  localparam logic [COUNT_W-1:0] LOW_VAL = COUNT_W'(LOW_THRESH);

  logic [1:0] range_reg;
  logic [9:0] decade_reg;
  logic [9:0] decade_last;

  // Number of full GATE_CYCLES passes minus one for the current range.
  always_comb begin
    decade_last = 10'd0;
    case (range_reg)
      2'd0:    decade_last = 10'd0;
      2'd1:    decade_last = 10'd9;
      2'd2:    decade_last = 10'd99;
      default: decade_last = 10'd999;
    endcase
  end

  // Decade counter: advances each time the cycle timer completes a pass.
  always_ff @(posedge clock) begin
    if (reset) begin
      decade_reg <= '0;
    end else if (state_reg == GATE) begin
      if (timer_reg == GATE_LAST) begin
        decade_reg <= decade_reg + 10'd1;
      end
    end else begin
      decade_reg <= '0;
    end
  end

  // Range update at LATCH; the new range times the gate from the next CLEAR.
  always_ff @(posedge clock) begin
    if (reset) begin
      range_reg <= 2'd0;
    end else if (state_reg == LATCH) begin
      if ((bus.count < LOW_VAL) && (range_reg != 2'd3)) begin
        range_reg <= range_reg + 2'd1;
      end else if (over_max && (range_reg != 2'd0)) begin
        range_reg <= range_reg - 2'd1;
      end
    end
  end

  assign gate_done = (timer_reg == GATE_LAST) && (decade_reg == decade_last);
  assign bus.range = range_reg;
`else
  assign gate_done = (timer_reg == GATE_LAST);
  assign bus.range = 2'd0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next       = state_reg;
    count_clear_next = 1'b0;
    gate_next        = 1'b0;
    busy_next        = 1'b1;
    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (bus.start || bus.continuous) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        count_clear_next = 1'b1;
        state_next       = GATE;
      end
      GATE: begin
        gate_next = 1'b1;
        if (gate_done) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_done) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        state_next = bus.continuous ? CLEAR : IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Cycle timer: wraps at the end of each gate pass and each settle wait.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_reg <= '0;
    end else begin
      case (state_reg)
        GATE:    timer_reg <= (timer_reg == GATE_LAST) ? '0 : timer_reg + TIMER_W'(1);
        SETTLE:  timer_reg <= settle_done ? '0 : timer_reg + TIMER_W'(1);
        default: timer_reg <= '0;
      endcase
    end
  end

  // Result latch: saturate to the displayable maximum and flag overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      freq_reg       <= '0;
      overflow_reg   <= 1'b0;
      freq_valid_reg <= 1'b0;
    end else begin
      freq_valid_reg <= (state_reg == LATCH);
      if (state_reg == LATCH) begin
        freq_reg     <= over_max ? MAX_VAL : bus.count;
        overflow_reg <= over_max;
      end
    end
  end

  assign bus.count_clear = count_clear_next;
  assign bus.gate        = gate_next;
  assign bus.busy        = busy_next;
  assign bus.freq        = freq_reg;
  assign bus.freq_valid  = freq_valid_reg;
  assign bus.overflow    = overflow_reg;

endmodule
